// File: rtl/reaction_measure_state.sv
// Reaction timer measurement stage: random wait, go LED, BCD millisecond count until KEY[0] press.
// Freezes the score on DONE (out_state=3); dropping en returns to IDLE with digits held.
module reaction_measure_state #(
  parameter int CLK_PER_MS   = 50000,
  parameter int MIN_DELAY_MS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] KEY,
  output logic       led_go,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [3:0] score_c,
  output logic [3:0] score_d,
  output logic [3:0] out_state
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_GO   = 3'd2,
    S_FOUL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [12:0] dly_cnt_q, dly_cnt_d;
  logic [12:0] delay_ms_q, delay_ms_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        sync1_q, sync2_q, sync_prev_q, press_q;
  logic [3:0]  a_q, b_q, c_q, d_q;
  logic [3:0]  a_d, b_d, c_d, d_d;
  logic [3:0]  a_inc, b_inc, c_inc, d_inc;
  logic        ms_tick;
  logic        key1_unused;

  assign key1_unused = KEY[1];
  assign ms_tick     = (presc_q == PW'(CLK_PER_MS - 1));
  assign lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Cascaded BCD increment; the thousands digit never wraps because GO exits at 9999.
  always_comb begin
    a_inc = a_q;
    b_inc = b_q;
    c_inc = c_q;
    d_inc = d_q;
    if (a_q != 4'd9) begin
      a_inc = a_q + 4'd1;
    end else begin
      a_inc = 4'd0;
      if (b_q != 4'd9) begin
        b_inc = b_q + 4'd1;
      end else begin
        b_inc = 4'd0;
        if (c_q != 4'd9) begin
          c_inc = c_q + 4'd1;
        end else begin
          c_inc = 4'd0;
          if (d_q != 4'd9) d_inc = d_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    delay_ms_d = delay_ms_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    d_d        = d_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          delay_ms_d = 13'(MIN_DELAY_MS) + {1'b0, lfsr_q[11:0]};
          dly_cnt_d  = 13'd0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (press_q) begin
          state_d = S_FOUL;
        end else if (dly_cnt_q == delay_ms_q) begin
          {d_d, c_d, b_d, a_d} = 16'h0000;
          state_d = S_GO;
        end else if (ms_tick) begin
          dly_cnt_d = dly_cnt_q + 13'd1;
        end
      end
      S_GO: begin
        // A press in the same cycle as a tick blocks that increment.
        if (press_q) begin
          state_d = S_DONE;
        end else if (ms_tick) begin
          {d_d, c_d, b_d, a_d} = {d_inc, c_inc, b_inc, a_inc};
          if ({d_inc, c_inc, b_inc, a_inc} == 16'h9999) state_d = S_DONE;
        end
      end
      S_FOUL: begin
        {d_d, c_d, b_d, a_d} = 16'h9999;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !en) begin
      state_d = S_IDLE;
      {d_d, c_d, b_d, a_d} = {d_q, c_q, b_q, a_q};
    end
  end

  // Prescaler restarts on every state change so the first tick lands a full ms after entry.
  always_comb begin
    if (state_d != state_q || ms_tick) presc_d = '0;
    else                               presc_d = presc_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      dly_cnt_q   <= 13'd0;
      delay_ms_q  <= 13'd0;
      lfsr_q      <= 16'hACE1;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync_prev_q <= 1'b1;
      press_q     <= 1'b0;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      c_q         <= 4'd0;
      d_q         <= 4'd0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      dly_cnt_q   <= dly_cnt_d;
      delay_ms_q  <= delay_ms_d;
      lfsr_q      <= lfsr_d;
      sync1_q     <= KEY[0];
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
      press_q     <= sync_prev_q & ~sync2_q;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
    end
  end

  assign led_go    = (state_q == S_GO);
  assign out_state = (state_q == S_DONE) ? 4'd3 : 4'd2;
  assign score_a   = a_q;
  assign score_b   = b_q;
  assign score_c   = c_q;
  assign score_d   = d_q;

endmodule
